// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake through a one-word holding
// register, then start bit, BITS data bits LSB first, optional parity bit
// and 1 or 2 stop bits on the tx line. Every bit lasts CLK/BAUD_RATE cycles.
module uart_tx #(
  parameter int CLK       = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int BITS      = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] data,
  input  logic            valid,
  output logic            ready,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int CLK_DIVISOR = CLK / BAUD_RATE;
  localparam int BAUD_W      = $clog2(CLK_DIVISOR) + 1;
  localparam int BIT_W       = $clog2(BITS) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIVISOR - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_cnt_n;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_n;
  logic [BITS-1:0]   shift_reg;
  logic [BITS-1:0]   shift_reg_n;
  logic              parity_bit;
  logic              parity_bit_n;

  logic [BITS-1:0]   hold_reg;
  logic              hold_full;

  logic              baud_end;
  logic              load;
  logic              frame_end;

  // The holding register only ever accepts while empty, so an accept and an
  // engine load can never land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else begin
      if (load) begin
        hold_full <= 1'b0;
      end
      if (valid && !hold_full) begin
        hold_reg  <= data;
        hold_full <= 1'b1;
      end
    end
  end

  // Engine state register; reset drops any frame in flight immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_reg_n;
      parity_bit <= parity_bit_n;
    end
  end

  // Next-state logic; a load from the holding register overrides the normal
  // transition so a queued word follows the last stop cycle with no gap.
  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_cnt_n    = bit_cnt;
    shift_reg_n  = shift_reg;
    parity_bit_n = parity_bit;
    load         = 1'b0;
    baud_end     = (baud_cnt == BAUD_LAST);
    frame_end    = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) begin
          load = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_n  = '0;
          shift_reg_n = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? PARITY_BIT : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      PARITY_BIT: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = STOP;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            frame_end = 1'b1;
            bit_cnt_n = '0;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (load) begin
      state_n      = START;
      baud_cnt_n   = '0;
      bit_cnt_n    = '0;
      shift_reg_n  = hold_reg;
      parity_bit_n = (^hold_reg) ^ (PARITY == 1);
    end
  end

  // Line level decoded straight from the engine registers.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:      tx = 1'b0;
      DATA:       tx = shift_reg[0];
      PARITY_BIT: tx = parity_bit;
      default:    tx = 1'b1;
    endcase
  end

  assign ready = !hold_full;
  assign busy  = (state != IDLE);
  assign done  = frame_end;

endmodule
